// File: rtl/code_seq_pkg.sv
// +--------------------------------------------------------------------------+
// | code_seq_pkg -- shared encodings for the code sequencer   | rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

package code_seq_pkg;

  localparam logic [1:0] C_OP_LOAD = 2'b00;
  localparam logic [1:0] C_OP_RUN  = 2'b01;
  localparam logic [1:0] C_OP_STOP = 2'b10;
  localparam logic [1:0] C_OP_STEP = 2'b11;

  localparam logic C_MODE_BIN = 1'b0;
  localparam logic C_MODE_ROT = 1'b1;
  localparam logic C_DIR_UP   = 1'b0;
  localparam logic C_DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_prescaler.sv
// +--------------------------------------------------------------------------+
// | seq_prescaler -- counts 0..div, ticks at terminal count   | rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module seq_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  // A clear wins over a terminal count; a count above div wraps naturally.
  assign tick = en & ~clr & (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/code_sequencer.sv
// +--------------------------------------------------------------------------+
// | code_sequencer -- command-driven 4-bit count/rotate seq.  | rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module code_sequencer
  import code_seq_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [3:0]         cmd_data,
  input  logic               dir,
  input  logic               mode,
  input  logic [PRESC_W-1:0] div,
  output logic [3:0]         code,
  output logic               code_valid,
  output logic               busy,
  output logic               wrap
);

  state_e     state_q, state_d;
  logic [3:0] code_q, code_d;
  logic       code_valid_q, code_valid_d;
  logic       wrap_q, wrap_d;

  logic       w_cmd_acc;
  logic       w_presc_clr;
  logic       w_tick;
  logic       w_advance;
  logic [4:0] w_next;

  // Returns {wrap, next code}; rotation never reports a wrap.
  function automatic logic [4:0] next_code(input logic [3:0] cur,
                                           input logic       m,
                                           input logic       d);
    logic [4:0] r;
    r = {1'b0, cur};
    if (m == C_MODE_ROT) begin
      r = (d == C_DIR_UP) ? {1'b0, cur[0], cur[3:1]} : {1'b0, cur[2:0], cur[3]};
    end else if (d == C_DIR_UP) begin
      r = {cur == 4'hF, cur + 4'd1};
    end else begin
      r = {cur == 4'h0, cur - 4'd1};
    end
    return r;
  endfunction

  // rst_n gates ready directly so it drops the moment reset asserts.
  assign cmd_ready   = en & rst_n & (state_q != ST_STEP);
  assign w_cmd_acc   = cmd_valid & cmd_ready;
  assign w_presc_clr = w_cmd_acc & (cmd_op != C_OP_STEP);
  assign w_next      = next_code(code_q, mode, dir);

  seq_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en & (state_q == ST_RUN)),
    .clr   (w_presc_clr),
    .div   (div),
    .tick  (w_tick)
  );

  // Any command accepted in RUN pre-empts a coincident terminal count.
  assign w_advance = en & ((state_q == ST_STEP) |
                           ((state_q == ST_RUN) & w_tick & ~w_cmd_acc));

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
    wrap_d       = 1'b0;

    if (w_cmd_acc) begin
      case (cmd_op)
        C_OP_LOAD: begin
          code_d       = cmd_data;
          code_valid_d = 1'b1;
        end
        C_OP_RUN:  state_d = ST_RUN;
        C_OP_STOP: state_d = ST_IDLE;
        C_OP_STEP: state_d = ST_STEP;
        default:   state_d = state_q;
      endcase
    end

    if (en && (state_q == ST_STEP)) begin
      state_d = ST_IDLE;
    end

    if (w_advance) begin
      wrap_d       = w_next[4];
      code_d       = w_next[3:0];
      code_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      code_q       <= 4'h0;
      code_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      wrap_q       <= wrap_d;
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign wrap       = wrap_q;
  assign busy       = (state_q == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_code_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_code_sequencer -- vectors, corner sequences, random vs model | rev 1.0|
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_code_sequencer;
  import code_seq_pkg::*;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic       dir;
  logic       mode;
  logic [7:0] div;
  logic [3:0] code;
  logic       code_valid;
  logic       busy;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  // Reference model: state 0 idle, 1 run, 2 step.
  int m_st, m_cnt, m_code, m_v, m_w;

  typedef struct {
    logic       cv;
    logic [1:0] op;
    logic [3:0] data;
    logic       mode;
    logic [3:0] e_code;
    logic       e_v, e_w, e_b, e_r;
  } vec_t;

  vec_t tbl[13];

  code_sequencer #(.PRESC_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .dir        (dir),
    .mode       (mode),
    .div        (div),
    .code       (code),
    .code_valid (code_valid),
    .busy       (busy),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic cv, input logic [1:0] op, input logic [3:0] data,
                              input logic md, input logic [3:0] ec, input logic ev,
                              input logic ew, input logic eb, input logic er);
    vec_t v;
    v.cv = cv; v.op = op; v.data = data; v.mode = md;
    v.e_code = ec; v.e_v = ev; v.e_w = ew; v.e_b = eb; v.e_r = er;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [3:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_adv(input int max, output int n);
    n = 0;
    while (n < max) begin
      cyc();
      n++;
      if (code_valid) break;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; cmd_valid = 1'b0; cmd_op = C_OP_LOAD;
    cmd_data = 4'h0; dir = 1'b0; mode = 1'b0; div = 8'd0;
    repeat (2) cyc();
    rst_n = 1'b1;
    m_st = 0; m_cnt = 0; m_code = 0;
  endtask

  task automatic model_step();
    int adv;
    adv = 0; m_v = 0; m_w = 0;
    if (en) begin
      if (m_st == 2) begin
        adv = 1; m_st = 0;
      end else if (cmd_valid) begin
        case (cmd_op)
          C_OP_LOAD: begin m_code = int'(cmd_data); m_v = 1; m_cnt = 0; end
          C_OP_RUN:  begin m_st = 1; m_cnt = 0; end
          C_OP_STOP: begin m_st = 0; m_cnt = 0; end
          default:   m_st = 2;
        endcase
      end else if (m_st == 1) begin
        if (m_cnt == int'(div)) begin adv = 1; m_cnt = 0; end
        else m_cnt = (m_cnt + 1) % 256;
      end
      if (adv != 0) begin
        m_v = 1;
        if (mode) begin
          if (dir) m_code = ((m_code * 2) % 16) + (m_code / 8);
          else     m_code = (m_code / 2) + ((m_code % 2) * 8);
        end else if (dir) begin
          m_w = (m_code == 0) ? 1 : 0;
          m_code = (m_code + 15) % 16;
        end else begin
          m_w = (m_code == 15) ? 1 : 0;
          m_code = (m_code + 1) % 16;
        end
      end
    end
  endtask

  initial begin
    int n, c;

    // LOAD E, RUN div0 count-up, STOP, then LOAD 8 and stepped rotation.
    tbl[0]  = mk(Y, C_OP_LOAD, 4'hE, N, 4'hE, Y, N, N, Y);
    tbl[1]  = mk(Y, C_OP_RUN,  4'h0, N, 4'hE, N, N, Y, Y);
    tbl[2]  = mk(N, C_OP_RUN,  4'h0, N, 4'hF, Y, N, Y, Y);
    tbl[3]  = mk(N, C_OP_RUN,  4'h0, N, 4'h0, Y, Y, Y, Y);
    tbl[4]  = mk(N, C_OP_RUN,  4'h0, N, 4'h1, Y, N, Y, Y);
    tbl[5]  = mk(Y, C_OP_STOP, 4'h0, N, 4'h1, N, N, N, Y);
    tbl[6]  = mk(Y, C_OP_LOAD, 4'h8, N, 4'h8, Y, N, N, Y);
    tbl[7]  = mk(Y, C_OP_STEP, 4'h0, Y, 4'h8, N, N, N, N);
    tbl[8]  = mk(Y, C_OP_STEP, 4'h0, Y, 4'h4, Y, N, N, Y);
    tbl[9]  = mk(Y, C_OP_STEP, 4'h0, Y, 4'h4, N, N, N, N);
    tbl[10] = mk(Y, C_OP_STEP, 4'h0, Y, 4'h2, Y, N, N, Y);
    tbl[11] = mk(Y, C_OP_STEP, 4'h0, Y, 4'h2, N, N, N, N);
    tbl[12] = mk(Y, C_OP_STEP, 4'h0, Y, 4'h1, Y, N, N, Y);

    rst_n = 1'b0; en = 1'b1; cmd_valid = 1'b0; cmd_op = C_OP_LOAD;
    cmd_data = 4'h0; dir = 1'b0; mode = 1'b0; div = 8'd0;
    #12;
    chk("reset code", int'(code), 0);
    chk("reset code_valid", int'(code_valid), 0);
    chk("reset wrap", int'(wrap), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset cmd_ready", int'(cmd_ready), 0);
    cyc();
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cmd_valid = tbl[i].cv; cmd_op = tbl[i].op; cmd_data = tbl[i].data;
      mode = tbl[i].mode; dir = 1'b0; div = 8'd0; en = 1'b1;
      cyc();
      chk($sformatf("vec%0d code", i), int'(code), int'(tbl[i].e_code));
      chk($sformatf("vec%0d code_valid", i), int'(code_valid), int'(tbl[i].e_v));
      chk($sformatf("vec%0d wrap", i), int'(wrap), int'(tbl[i].e_w));
      chk($sformatf("vec%0d busy", i), int'(busy), int'(tbl[i].e_b));
      chk($sformatf("vec%0d cmd_ready", i), int'(cmd_ready), int'(tbl[i].e_r));
    end
    cmd_valid = 1'b0;

    // div=3 cadence and an en-low stall mid-count.
    mode = 1'b0; dir = 1'b0; div = 8'd3;
    cmd(C_OP_LOAD, 4'h0);
    cmd(C_OP_RUN, 4'h0);
    wait_adv(10, n);
    chk("div3 first advance cycles", n, 4);
    chk("div3 first code", int'(code), 1);
    wait_adv(10, n);
    chk("div3 second advance cycles", n, 4);
    chk("div3 second code", int'(code), 2);
    cyc();
    en = 1'b0;
    cyc();
    chk("en low code_valid", int'(code_valid), 0);
    chk("en low cmd_ready", int'(cmd_ready), 0);
    cyc();
    chk("en low code held", int'(code), 2);
    en = 1'b1;
    wait_adv(10, n);
    chk("en low delayed advance", n, 3);
    chk("en low resumed code", int'(code), 3);

    // Down-count wrap via STEP, then LOAD mid-RUN restarts the cadence.
    cmd(C_OP_STOP, 4'h0);
    cmd(C_OP_LOAD, 4'h0);
    dir = 1'b1;
    cmd(C_OP_STEP, 4'h0);
    cyc();
    chk("down wrap code", int'(code), 15);
    chk("down wrap pulse", int'(wrap), 1);
    chk("down wrap code_valid", int'(code_valid), 1);
    dir = 1'b0;
    cmd(C_OP_RUN, 4'h0);
    cyc(); cyc();
    cmd(C_OP_LOAD, 4'h5);
    chk("load in run code", int'(code), 5);
    chk("load in run code_valid", int'(code_valid), 1);
    chk("load in run busy", int'(busy), 1);
    wait_adv(10, n);
    chk("after load advance cycles", n, 4);
    chk("after load code", int'(code), 6);

    // Asynchronous reset mid-RUN.
    div = 8'd0;
    cmd(C_OP_LOAD, 4'h3);
    cmd(C_OP_RUN, 4'h0);
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (code == 4'h7) break;
    end
    chk("pre-reset code", int'(code), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset code", int'(code), 0);
    chk("async reset busy", int'(busy), 0);
    chk("async reset cmd_ready", int'(cmd_ready), 0);
    cyc(); cyc();
    rst_n = 1'b1;
    c = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (code != 4'h0 || code_valid || busy) c++;
    end
    chk("post-reset idle cycles disturbed", c, 0);
    chk("post-reset cmd_ready", int'(cmd_ready), 1);

    // STOP in RUN freezes the code.
    cmd(C_OP_RUN, 4'h0);
    cyc(); cyc(); cyc();
    c = int'(code);
    cmd(C_OP_STOP, 4'h0);
    chk("stop busy", int'(busy), 0);
    chk("stop code held", int'(code), c);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (code_valid || int'(code) != c) n++;
    end
    chk("stop quiet cycles disturbed", n, 0);

    // Randomised traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_data  = 4'($urandom);
      dir       = 1'($urandom);
      mode      = 1'($urandom);
      if ($urandom_range(0, 49) == 0) div = 8'($urandom_range(0, 5));
      model_step();
      cyc();
      chk("rand code", int'(code), m_code);
      chk("rand code_valid", int'(code_valid), m_v);
      chk("rand wrap", int'(wrap), m_w);
      chk("rand busy", int'(busy), (m_st == 1) ? 1 : 0);
      chk("rand cmd_ready", int'(cmd_ready), (en && m_st != 2) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/code_sequencer.md
CODE_SEQUENCER -- requirements
Module: code_sequencer

Interface
REQ-001 The block SHALL have one parameter: PRESC_W, default 8, width of the advance-rate divider.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port en, input, 1 bit: global enable; when low, all state freezes.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit: command accepted this cycle when cmd_valid is also high.
REQ-007 The block SHALL have port cmd_op, input, 2 bits: 00 LOAD, 01 RUN, 10 STOP, 11 STEP.
REQ-008 The block SHALL have port cmd_data, input, 4 bits: LOAD value.
REQ-009 The block SHALL have port dir, input, 1 bit: 0 up / rotate-right, 1 down / rotate-left.
REQ-010 The block SHALL have port mode, input, 1 bit: 0 binary count, 1 4-bit rotate.
REQ-011 The block SHALL have port div, input, PRESC_W bits: cycles per advance minus 1.
REQ-012 The block SHALL have port code, output, 4 bits: current code, feeding the downstream 4-to-16 one-hot decoder.
REQ-013 The block SHALL have port code_valid, output, 1 bit: one-cycle pulse each time code takes a new value.
REQ-014 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-015 The block SHALL have port wrap, output, 1 bit: one-cycle pulse on a binary wrap (15->0 up, 0->15 down).

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and STEP.
REQ-017 cmd_ready SHALL equal en AND (state != STEP), and a command SHALL be accepted when cmd_valid AND cmd_ready are both high.
REQ-018 An accepted LOAD SHALL update code to cmd_data on the next edge, pulse code_valid that cycle, clear the prescaler, and leave the state unchanged.
REQ-019 An accepted RUN SHALL cause IDLE->RUN with the prescaler cleared, and SHALL only clear the prescaler when already in RUN.
REQ-020 An accepted STOP SHALL cause any state->IDLE with the prescaler cleared and code held.
REQ-021 An accepted STEP SHALL cause IDLE/RUN->STEP; the STEP state SHALL perform exactly one advance and then return to IDLE in one cycle.
REQ-022 In RUN with en high, the prescaler SHALL count 0..div; at count==div the block SHALL advance and reset the count to 0.
REQ-023 With div=0, RUN SHALL advance every cycle; in general the first advance SHALL occur div+1 cycles after RUN is accepted.
REQ-024 An advance with mode 0 SHALL set code to code+1 mod 16 when dir=0, or code-1 mod 16 when dir=1.
REQ-025 An advance with mode 1 SHALL set code to {code[0],code[3:1]} when dir=0, or {code[2:0],code[3]} when dir=1; wrap SHALL never pulse in mode 1.
REQ-026 code, code_valid and wrap SHALL be registered, with updates visible the cycle after the accepting or terminal-count edge.
REQ-027 code_valid SHALL pulse on every advance, including rotate advances that leave code unchanged (0000, 1111).
REQ-028 While en is low, the prescaler, code and state SHALL hold, and code_valid and wrap SHALL be 0.
REQ-029 dir, mode and div SHALL be sampled at the advance edge; changing div mid-count SHALL take effect against the current count, and a count already above the new div SHALL wrap through 2^PRESC_W.

Reset
REQ-030 While rst_n is low: state=IDLE, prescaler=0, code=4'h0, code_valid=0, wrap=0, busy=0, cmd_ready=0.
REQ-031 Reset assertion mid-RUN or mid-STEP SHALL abort immediately with no advance and no pulses; operation SHALL resume on the first edge after rst_n deasserts.

Structure
REQ-032 The shared package code_seq_pkg SHALL hold the cmd_op encodings, the state enum (IDLE/RUN/STEP) and the mode/dir constants.
REQ-033 The prescaler SHALL be a sub-module seq_prescaler (ports clk, rst_n, en, clr, div; output tick).
REQ-034 All advance logic SHALL reside in one combinational next-code function within code_sequencer.

Verification
REQ-035 The bench SHALL cover: LOAD 4'hE, RUN, div=0, mode 0, dir 0 -> codes E,F,0,1 on consecutive cycles, wrap high only with code=0, code_valid high each cycle.
REQ-036 The bench SHALL cover: LOAD 4'h8, STEP x3, mode 1, dir 0 -> codes 4,2,1, each STEP accepted only after returning to IDLE, busy 0 throughout.
REQ-037 The bench SHALL cover: RUN with div=3 -> advances every 4 cycles; en low for 2 cycles mid-count -> next advance delayed exactly 2 cycles.
REQ-038 The bench SHALL cover: mode 0, dir 1, code 0, one advance -> code F, wrap 1; LOAD 4'h5 during RUN -> code 5 next cycle, next advance div+1 cycles later.
REQ-039 The bench SHALL cover: rst_n low mid-RUN at code 7 -> code 0, IDLE, cmd_ready 0 asynchronously; after release, no advance until RUN is reissued.
REQ-040 The bench SHALL cover: STOP in RUN -> busy 0 the next cycle, code held, and no code_valid for 20 cycles.
